// File: rtl/multicycle_control_unit_if.sv
// Bus bundle between the multi-cycle control unit and its decoder, instruction
// memory, register file and data memory.
`default_nettype none

interface multicycle_control_unit_if;
  logic [15:0] inst_address;
  logic [31:0] instr_in;
  logic [31:0] ir;
  logic [2:0]  opcode;
  logic [4:0]  reg_addr_0;
  logic [4:0]  reg_addr_1;
  logic [4:0]  reg_addr_2;
  logic [14:0] addr;
  logic [4:0]  rf_read_address_0;
  logic [4:0]  rf_read_address_1;
  logic [31:0] read_data_0;
  logic [31:0] read_data_1;
  logic        rf_write_en;
  logic [4:0]  rf_write_address;
  logic [31:0] rf_write_data;
  logic        dm_write_en;
  logic [14:0] dm_address;
  logic [31:0] dm_write_data;
  logic [31:0] mem_read_data;
  logic [2:0]  state;
  logic        halted;
  logic [15:0] retired;

  modport master (
    output inst_address, ir, rf_read_address_0, rf_read_address_1,
           rf_write_en, rf_write_address, rf_write_data,
           dm_write_en, dm_address, dm_write_data, state, halted, retired,
    input  instr_in, opcode, reg_addr_0, reg_addr_1, reg_addr_2, addr,
           read_data_0, read_data_1, mem_read_data
  );

  modport slave (
    input  inst_address, ir, rf_read_address_0, rf_read_address_1,
           rf_write_en, rf_write_address, rf_write_data,
           dm_write_en, dm_address, dm_write_data, state, halted, retired,
    output instr_in, opcode, reg_addr_0, reg_addr_1, reg_addr_2, addr,
           read_data_0, read_data_1, mem_read_data
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// Multi-cycle fetch/sequencing stage: owns PC and IR and steps each instruction
// through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, producing RF and DM controls.
`default_nettype none

module multicycle_control_unit #(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic                       clk,
  input  logic                       rst,
  multicycle_control_unit_if.master  bus
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    HALTED    = 3'd5
  } state_t;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b100;
  localparam logic [2:0] OP_AND   = 3'b101;
  localparam logic [2:0] OP_JUMP  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  state_t      state_q;
  logic [15:0] pc;
  logic [31:0] ir_q;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] aluout;
  logic [31:0] mdr;
  logic [15:0] retired_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      pc        <= PC_RESET;
      ir_q      <= 32'd0;
      a         <= 32'd0;
      b         <= 32'd0;
      aluout    <= 32'd0;
      mdr       <= 32'd0;
      retired_q <= 16'd0;
    end else begin
      case (state_q)
        FETCH: begin
          ir_q    <= bus.instr_in;
          state_q <= DECODE;
        end
        DECODE: begin
          a  <= bus.read_data_0;
          b  <= bus.read_data_1;
          pc <= pc + 16'd1;
          case (bus.opcode)
            OP_NOP: begin
              retired_q <= retired_q + 16'd1;
              state_q   <= FETCH;
            end
            OP_JUMP: begin
              // Later assignment wins over the PC increment above.
              pc        <= {1'b0, bus.addr};
              retired_q <= retired_q + 16'd1;
              state_q   <= FETCH;
            end
            OP_HALT: begin
              retired_q <= retired_q + 16'd1;
              state_q   <= HALTED;
            end
            default: state_q <= EXECUTE;
          endcase
        end
        EXECUTE: begin
          case (bus.opcode)
            OP_ADD: begin
              aluout  <= a + b;
              state_q <= WRITEBACK;
            end
            OP_SUB: begin
              aluout  <= a - b;
              state_q <= WRITEBACK;
            end
            OP_AND: begin
              aluout  <= a & b;
              state_q <= WRITEBACK;
            end
            OP_LOAD, OP_STORE: state_q <= MEMORY;
            default:           state_q <= FETCH;
          endcase
        end
        MEMORY: begin
          if (bus.opcode == OP_LOAD) begin
            mdr     <= bus.mem_read_data;
            state_q <= WRITEBACK;
          end else begin
            retired_q <= retired_q + 16'd1;
            state_q   <= FETCH;
          end
        end
        WRITEBACK: begin
          retired_q <= retired_q + 16'd1;
          state_q   <= FETCH;
        end
        HALTED:  state_q <= HALTED;
        default: state_q <= FETCH;
      endcase
    end
  end

  assign bus.inst_address      = pc;
  assign bus.ir                = ir_q;
  assign bus.rf_read_address_0 = (bus.opcode == OP_STORE) ? bus.reg_addr_0 : bus.reg_addr_1;
  assign bus.rf_read_address_1 = bus.reg_addr_2;

  // Strobes are masked by rst so a write pending at a reset edge is dropped.
  assign bus.rf_write_en      = (state_q == WRITEBACK) && !rst;
  assign bus.rf_write_address = bus.reg_addr_0;
  assign bus.rf_write_data    = (bus.opcode == OP_LOAD) ? mdr : aluout;
  assign bus.dm_write_en      = (state_q == MEMORY) && (bus.opcode == OP_STORE) && !rst;
  assign bus.dm_address       = bus.addr;
  assign bus.dm_write_data    = a;

  assign bus.state   = state_q;
  assign bus.halted  = (state_q == HALTED);
  assign bus.retired = retired_q;

endmodule

`default_nettype wire
